// File: rtl/pack1_deser_pkg.sv
// pack1 payload type and byte-stream helpers for the pack1 deserialiser.
// Optional checksum build: PACK1_DESER_CHECKSUM_EN.
package P_packedStruct;

    typedef struct packed signed {
        int        a;
        shortint   b;
        byte       c;
        bit [7:0]  d;
    } pack1;

endpackage

package P_pack1Stream;

    localparam int PACK1_BYTES = 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_CHECK,
        S_HOLD
    } pack1_deser_state_e;

    // XOR of all payload bytes; the sender appends this as byte 8.
    function automatic byte xsum8(bit [63:0] w);
        byte s;
        s = 8'h00;
        for (int i = 0; i < PACK1_BYTES; i++) begin
            s = s ^ w[8*i +: 8];
        end
        return s;
    endfunction

endpackage

// File: rtl/pack1_deser.sv
// Reassembles big-endian byte frames into pack1 words (single output slot).
// Define PACK1_DESER_CHECKSUM_EN for a trailing XOR checksum byte per frame.
module pack1_deser
    import P_packedStruct::*;
    import P_pack1Stream::*;
#(
    parameter int ABORT_CNT_W = 8
) (
    input  logic                   i_clk,
    input  logic                   i_arstn,
    input  logic [7:0]             i_byte_data,
    input  logic                   i_byte_sof,
    input  logic                   i_byte_valid,
    output logic                   o_byte_ready,
    output logic [63:0]            o_pack,
    output logic                   o_pack_valid,
    input  logic                   i_pack_ready,
    output logic                   o_frame_err,
    output logic [ABORT_CNT_W-1:0] o_abort_cnt
);

    localparam logic [2:0] LAST_IDX = 3'(PACK1_BYTES - 1);

    pack1_deser_state_e state_q, state_d;

    logic [2:0]             idx_q, idx_d;
    logic [63:0]            frame_q, frame_d;
    pack1                   pack_q, pack_d;
    logic                   err_q, err_d;
    logic                   abort_d;
    logic [ABORT_CNT_W-1:0] cnt_q;
    logic                   rdy_en_q;
    logic                   accept;

`ifdef PACK1_DESER_CHECKSUM_EN
    logic [7:0]             sum_q, sum_d;
    logic                   tail_q, tail_d;
`endif

    assign o_byte_ready = rdy_en_q &&
                          (state_q == S_IDLE || state_q == S_COLLECT);
    assign accept       = i_byte_valid && o_byte_ready;
    assign o_pack       = pack_q;
    assign o_pack_valid = (state_q == S_HOLD);
    assign o_frame_err  = err_q;
    assign o_abort_cnt  = cnt_q;

    // State and datapath registers; ready is held low until the first edge out of reset.
    always_ff @(posedge i_clk or negedge i_arstn) begin
        if (!i_arstn) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            frame_q  <= '0;
            pack_q   <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
            rdy_en_q <= 1'b0;
`ifdef PACK1_DESER_CHECKSUM_EN
            sum_q    <= '0;
            tail_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            frame_q  <= frame_d;
            pack_q   <= pack_d;
            err_q    <= err_d;
            rdy_en_q <= 1'b1;
            if (abort_d && cnt_q != '1) begin
                cnt_q <= cnt_q + 1'b1;
            end
`ifdef PACK1_DESER_CHECKSUM_EN
            sum_q    <= sum_d;
            tail_q   <= tail_d;
`endif
        end
    end

    // Next-state, byte placement and discard decisions.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        frame_d = frame_q;
        pack_d  = pack_q;
        err_d   = 1'b0;
        abort_d = 1'b0;
`ifdef PACK1_DESER_CHECKSUM_EN
        sum_d   = sum_q;
        tail_d  = tail_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (accept && i_byte_sof) begin
                    frame_d[63:56] = i_byte_data;
                    idx_d          = 3'd1;
                    state_d        = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (accept && i_byte_sof) begin
                    // A new frame start restarts collection from byte 0.
                    abort_d        = 1'b1;
                    err_d          = 1'b1;
                    frame_d[63:56] = i_byte_data;
                    idx_d          = 3'd1;
`ifdef PACK1_DESER_CHECKSUM_EN
                    tail_d         = 1'b0;
`endif
                end else if (accept) begin
`ifdef PACK1_DESER_CHECKSUM_EN
                    if (tail_q) begin
                        sum_d   = i_byte_data;
                        tail_d  = 1'b0;
                        idx_d   = '0;
                        state_d = S_CHECK;
                    end else begin
                        frame_d[{~idx_q, 3'b000} +: 8] = i_byte_data;
                        if (idx_q == LAST_IDX) begin
                            tail_d = 1'b1;
                        end else begin
                            idx_d = idx_q + 3'd1;
                        end
                    end
`else
                    frame_d[{~idx_q, 3'b000} +: 8] = i_byte_data;
                    if (idx_q == LAST_IDX) begin
                        pack_d  = frame_d;
                        idx_d   = '0;
                        state_d = S_HOLD;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
`endif
                end
            end
            S_CHECK: begin
`ifdef PACK1_DESER_CHECKSUM_EN
                if ($unsigned(xsum8(frame_q)) == sum_q) begin
                    pack_d  = frame_q;
                    state_d = S_HOLD;
                end else begin
                    err_d   = 1'b1;
                    abort_d = 1'b1;
                    state_d = S_IDLE;
                end
`else
                state_d = S_IDLE;
`endif
            end
            S_HOLD: begin
                if (i_pack_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule
